// File: rtl/fp_enco_norm_if.sv
// Operand/result bundle between the arithmetic core, fp_enco_norm and the result register.
// Valid/ready on both sides: a beat moves on the rising edge where valid && ready;
// the sender holds its payload stable while valid is high and ready is low.
interface fp_enco_norm_if;
  logic        in_valid;
  logic        in_ready;
  logic        Signo_R;
  logic [9:0]  Exponente_R;
  logic [27:0] Mantissa_R;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Float_num_R;
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;

  modport master (
    output in_valid, Signo_R, Exponente_R, Mantissa_R, out_ready,
    input  in_ready, out_valid, Float_num_R, Overflow, Underflow, Inexact
  );

  modport slave (
    input  in_valid, Signo_R, Exponente_R, Mantissa_R, out_ready,
    output in_ready, out_valid, Float_num_R, Overflow, Underflow, Inexact
  );
endinterface

// File: rtl/fp_enco_norm.sv
// Normalizes an unpacked sign/exponent/raw mantissa one shift per cycle, rounds to
// nearest-even and packs an IEEE-754 single. One operand in flight at a time.
module fp_enco_norm #(
  parameter int MAX_SHIFT = 27
) (
  input  logic             clk,
  input  logic             rst,
  fp_enco_norm_if.slave    bus,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(MAX_SHIFT + 1);
  localparam logic signed [10:0] EXP_FLUSH = -11'sd25;
  localparam logic signed [10:0] EXP_ONE   = 11'sd1;
  localparam logic signed [10:0] EXP_INF   = 11'sd255;

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

  state_t state, state_n;
  logic              sign_q, sign_n;
  logic signed [10:0] exp_q, exp_n;
  logic [27:0]       mant_q, mant_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic              zero_q, zero_n;
  logic              flush_q, flush_n;
  logic              grs_q, grs_n;
  logic              out_valid_q, out_valid_n;
  logic [31:0]       float_q, float_n;
  logic              ovf_q, ovf_n, unf_q, unf_n, inx_q, inx_n;
  logic              rnd_inc;
  logic [24:0]       rnd_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      flush_q     <= 1'b0;
      grs_q       <= 1'b0;
      out_valid_q <= 1'b0;
      float_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      state       <= state_n;
      sign_q      <= sign_n;
      exp_q       <= exp_n;
      mant_q      <= mant_n;
      cnt_q       <= cnt_n;
      zero_q      <= zero_n;
      flush_q     <= flush_n;
      grs_q       <= grs_n;
      out_valid_q <= out_valid_n;
      float_q     <= float_n;
      ovf_q       <= ovf_n;
      unf_q       <= unf_n;
      inx_q       <= inx_n;
    end
  end

  always_comb begin
    state_n     = state;
    sign_n      = sign_q;
    exp_n       = exp_q;
    mant_n      = mant_q;
    cnt_n       = cnt_q;
    zero_n      = zero_q;
    flush_n     = flush_q;
    grs_n       = grs_q;
    out_valid_n = out_valid_q;
    float_n     = float_q;
    ovf_n       = ovf_q;
    unf_n       = unf_q;
    inx_n       = inx_q;
    // Nearest-even: round up on G unless it is an exact tie with an even LSB.
    rnd_inc     = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd_sum     = mant_q[27:3] + {24'd0, rnd_inc};

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_n  = bus.Signo_R;
          exp_n   = {bus.Exponente_R[9], bus.Exponente_R};
          mant_n  = bus.Mantissa_R;
          cnt_n   = '0;
          zero_n  = 1'b0;
          flush_n = 1'b0;
          grs_n   = 1'b0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (mant_q == 28'd0) begin
          zero_n  = 1'b1;
          state_n = ROUND;
        end else if (exp_q < EXP_FLUSH || cnt_q == CW'(MAX_SHIFT)) begin
          flush_n = 1'b1;
          state_n = DONE;
        end else if (mant_q[27] || exp_q < EXP_ONE) begin
          mant_n = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_n  = exp_q + 11'sd1;
          cnt_n  = cnt_q + CW'(1);
        end else if (!mant_q[26] && exp_q > EXP_ONE) begin
          mant_n = {mant_q[26:0], 1'b0};
          exp_n  = exp_q - 11'sd1;
          cnt_n  = cnt_q + CW'(1);
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        grs_n = |mant_q[2:0];
        if (rnd_sum[24]) begin
          mant_n = {1'b0, rnd_sum[24:1], 3'b000};
          exp_n  = exp_q + 11'sd1;
        end else begin
          mant_n = {rnd_sum, 3'b000};
        end
        state_n = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_n = 1'b1;
          if (zero_q) begin
            float_n = {sign_q, 31'd0};
            ovf_n = 1'b0; unf_n = 1'b0; inx_n = 1'b0;
          end else if (flush_q) begin
            float_n = {sign_q, 31'd0};
            ovf_n = 1'b0; unf_n = 1'b1; inx_n = 1'b1;
          end else if (exp_q >= EXP_INF) begin
            float_n = {sign_q, 8'hFF, 23'd0};
            ovf_n = 1'b1; unf_n = 1'b0; inx_n = 1'b1;
          end else if (!mant_q[26]) begin
            float_n = {sign_q, 8'h00, mant_q[25:3]};
            ovf_n = 1'b0; unf_n = grs_q; inx_n = grs_q;
          end else begin
            float_n = {sign_q, exp_q[7:0], mant_q[25:3]};
            ovf_n = 1'b0; unf_n = 1'b0; inx_n = grs_q;
          end
        end else if (bus.out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.Float_num_R = float_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;
  assign bus.Inexact     = inx_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_fp_enco_norm.sv
// Directed-vector bench for fp_enco_norm: table of operands with hand-computed results,
// plus back-pressure and mid-operation reset sequences.
module tb_fp_enco_norm;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_fail;

  fp_enco_norm_if bus ();

  fp_enco_norm #(.MAX_SHIFT(27)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               sign;
    logic signed [9:0]  exp;
    logic [27:0]        mant;
    logic [31:0]        res;
    logic               ovf;
    logic               unf;
    logic               inx;
    int                 lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic signed [9:0] e, input logic [27:0] m,
                     input logic [31:0] r, input logic ov, input logic uf, input logic ix,
                     input int lat);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.res = r;
    v.ovf = ov; v.unf = uf; v.inx = ix; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_op(input logic s, input logic signed [9:0] e, input logic [27:0] m);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.Signo_R     = s;
    bus.Exponente_R = e;
    bus.Mantissa_R  = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges after acceptance until out_valid is seen, or -1 on timeout.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   lat;
    string tag;
    v = vecs[idx];
    tag = $sformatf("vec%0d", idx);
    bus.out_ready = 1'b1;
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    drive_op(v.sign, v.exp, v.mant);
    wait_out(lat);
    if (lat < 0) begin
      chk({tag, ".timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, ".result"}, bus.Float_num_R, v.res);
    chk({tag, ".flags"}, {29'd0, bus.Overflow, bus.Underflow, bus.Inexact},
        {29'd0, v.ovf, v.unf, v.inx});
    if (v.lat > 0) chk({tag, ".latency"}, lat, v.lat);
    @(posedge clk);
    #1;
    chk({tag, ".out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [2:0]  held_flags;
    n_vec  = 0;
    n_fail = 0;
    bus.in_valid    = 1'b0;
    bus.Signo_R     = 1'b0;
    bus.Exponente_R = '0;
    bus.Mantissa_R  = '0;
    bus.out_ready   = 1'b0;

    //   sign  exp    mant          result        ov uf ix lat
    add(1'b0,  127, 28'h4000000, 32'h3F800000, 0, 0, 0, 3);
    add(1'b0,  127, 28'h8000000, 32'h40000000, 0, 0, 0, 4);
    add(1'b0,  150, 28'h0000008, 32'h3F800000, 0, 0, 0, 26);
    add(1'b0,  127, 28'h400000C, 32'h3F800002, 0, 0, 1, 3);
    add(1'b0,  127, 28'h4000004, 32'h3F800000, 0, 0, 1, 3);
    add(1'b0,  127, 28'h7FFFFFF, 32'h40000000, 0, 0, 1, 3);
    add(1'b1,  260, 28'h4000000, 32'hFF800000, 1, 0, 1, 3);
    add(1'b0,  -30, 28'h4000000, 32'h00000000, 0, 1, 1, 0);
    add(1'b0,    0, 28'h4000000, 32'h00400000, 0, 0, 0, 4);
    add(1'b1,  300, 28'h0000000, 32'h80000000, 0, 0, 0, 3);
    add(1'b0,    0, 28'h4000001, 32'h00400000, 0, 1, 1, 4);
    add(1'b0,    1, 28'h3FFFFFC, 32'h00800000, 0, 0, 1, 3);
    add(1'b1,  128, 28'h6000000, 32'hC0400000, 0, 0, 0, 3);
    add(1'b0,   10, 28'h0000008, 32'h00000200, 0, 0, 0, 12);
    add(1'b0,  254, 28'h7FFFFFF, 32'h7F800000, 1, 0, 1, 3);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset.float", bus.Float_num_R, 32'd0);
    chk("reset.flags", {29'd0, bus.Overflow, bus.Underflow, bus.Inexact}, 32'd0);
    chk("reset.state", {30'd0, dbg_state}, 32'd0);

    foreach (vecs[i]) run_vec(i);

    // Back-pressure: result and flags must hold, and new operands must be refused.
    bus.out_ready = 1'b0;
    drive_op(1'b0, 127, 28'h400000C);
    wait_out(lat);
    if (lat < 0) chk("bp.timeout", 32'd0, 32'd1);
    held       = 32'h3F800002;
    held_flags = 3'b001;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.Signo_R     = 1'b1;
    bus.Exponente_R = 10'd200;
    bus.Mantissa_R  = 28'h6000000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.valid", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d.float", c), bus.Float_num_R, held);
      chk($sformatf("bp%0d.flags", c), {29'd0, bus.Overflow, bus.Underflow, bus.Inexact},
          {29'd0, held_flags});
      chk($sformatf("bp%0d.in_ready", c), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp.release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp.still_idle", {30'd0, dbg_state}, 32'd0);
    run_vec(12);

    // Reset while normalizing a long left-shift operand.
    drive_op(1'b0, 150, 28'h0000008);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midrst.float", bus.Float_num_R, 32'd0);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) break;
    end
    chk("midrst.no_stale_result", {31'd0, bus.out_valid}, 32'd0);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
